// File: rtl/ddr2_wr_burst.sv
// Pairs buffered 64-bit words into 128-bit beats and issues BL4 writes to the MIG DDR2 user interface.
// Command and beat0 one edge after 4 words are buffered; beat1 stalls on app_wdf_afull; input drops on full.
module ddr2_wr_burst #(
    parameter int DI_WIDTH       = 64,
    parameter int APP_DATA_WIDTH = 128,
    parameter int ADDR_WIDTH     = 31,
    parameter int ADDR_INC       = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DI_WIDTH-1:0]         din,
    input  logic                        din_vd,
    input  logic                        flush,
    input  logic                        load_addr,
    input  logic [ADDR_WIDTH-1:0]       start_addr,
    input  logic                        phy_init_done,
    input  logic                        app_af_afull,
    input  logic                        app_wdf_afull,
    output logic                        app_af_wren,
    output logic [2:0]                  app_af_cmd,
    output logic [ADDR_WIDTH-1:0]       app_af_addr,
    output logic                        app_wdf_wren,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask_data,
    output logic                        busy,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int MW = DI_WIDTH / 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BEAT1 = 1'b1;

    logic [0:0]                  r_state;
    logic [DI_WIDTH-1:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]                 r_wr_ptr;
    logic [AW:0]                 r_rd_ptr;
    logic                        r_flush_pend;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [APP_DATA_WIDTH-1:0]   r_beat1_dat;
    logic [APP_DATA_WIDTH/8-1:0] r_beat1_msk;

    logic [AW:0]         w_count;
    logic                w_full;
    logic                w_wr;
    logic                w_have4;
    logic                w_launch;
    logic [2:0]          w_take;
    logic                w_beat1_ok;
    logic [DI_WIDTH-1:0] w_word  [4];
    logic [MW-1:0]       w_wmask [4];

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr       = din_vd && !w_full;
    assign w_have4    = (w_count >= (AW+1)'(4));
    assign w_take     = w_have4 ? 3'd4 : w_count[2:0];
    // BEAT1 always returns through IDLE; the IDLE launch still lands on the next edge, so bursts stay gapless.
    assign w_launch   = (r_state == S_IDLE) && phy_init_done && !app_af_afull && !app_wdf_afull &&
                        (w_have4 || (r_flush_pend && (w_count != '0)));
    assign w_beat1_ok = (r_state == S_BEAT1) && !app_wdf_afull;

    assign app_af_cmd = 3'b000;
    assign busy       = (w_count != '0) || r_flush_pend || (r_state != S_IDLE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_word[i]  = '0;
            w_wmask[i] = '1;
            if (3'(i) < w_take) begin
                w_word[i]  = r_mem[r_rd_ptr[AW-1:0] + AW'(i)];
                w_wmask[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_flush_pend      <= 1'b0;
            r_addr            <= '0;
            r_beat1_dat       <= '0;
            r_beat1_msk       <= '0;
            app_af_wren       <= 1'b0;
            app_af_addr       <= '0;
            app_wdf_wren      <= 1'b0;
            app_wdf_data      <= '0;
            app_wdf_mask_data <= '0;
            overflow          <= 1'b0;
        end else begin
            app_af_wren  <= 1'b0;
            app_wdf_wren <= 1'b0;

            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (din_vd && w_full)
                overflow <= 1'b1;

            if (w_launch) begin
                app_af_wren       <= 1'b1;
                app_af_addr       <= r_addr;
                app_wdf_wren      <= 1'b1;
                app_wdf_data      <= {w_word[1], w_word[0]};
                app_wdf_mask_data <= {w_wmask[1], w_wmask[0]};
                r_beat1_dat       <= {w_word[3], w_word[2]};
                r_beat1_msk       <= {w_wmask[3], w_wmask[2]};
                r_rd_ptr          <= r_rd_ptr + (AW+1)'(w_take);
                r_state           <= S_BEAT1;
            end else if (w_beat1_ok) begin
                app_wdf_wren      <= 1'b1;
                app_wdf_data      <= r_beat1_dat;
                app_wdf_mask_data <= r_beat1_msk;
                r_state           <= S_IDLE;
            end

            // A load in the launch cycle wins: the command already captured the old address.
            if (load_addr && (r_state == S_IDLE))
                r_addr <= start_addr;
            else if (w_launch)
                r_addr <= r_addr + ADDR_WIDTH'(ADDR_INC);

            if (flush)
                r_flush_pend <= 1'b1;
            else if (w_launch && ((AW+1)'(w_take) == w_count))
                r_flush_pend <= 1'b0;
            else if (r_flush_pend && (w_count == '0) && (r_state == S_IDLE))
                r_flush_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr2_wr_burst.sv
// Directed bench for ddr2_wr_burst: a per-cycle vector table plus hand-written multi-cycle corner cases.
module tb_ddr2_wr_burst;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  din = '0;
    logic         din_vd = 1'b0;
    logic         flush = 1'b0;
    logic         load_addr = 1'b0;
    logic [30:0]  start_addr = '0;
    logic         phy_init_done = 1'b0;
    logic         app_af_afull = 1'b0;
    logic         app_wdf_afull = 1'b0;
    logic         app_af_wren;
    logic [2:0]   app_af_cmd;
    logic [30:0]  app_af_addr;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask_data;
    logic         busy;
    logic         overflow;

    ddr2_wr_burst dut (
        .clk               (clk),
        .reset             (reset),
        .din               (din),
        .din_vd            (din_vd),
        .flush             (flush),
        .load_addr         (load_addr),
        .start_addr        (start_addr),
        .phy_init_done     (phy_init_done),
        .app_af_afull      (app_af_afull),
        .app_wdf_afull     (app_wdf_afull),
        .app_af_wren       (app_af_wren),
        .app_af_cmd        (app_af_cmd),
        .app_af_addr       (app_af_addr),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask_data (app_wdf_mask_data),
        .busy              (busy),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vd;
        logic [63:0]  d;
        logic         fl;
        logic         ld;
        logic [30:0]  sa;
        logic         phy;
        logic         e_af;
        logic [30:0]  e_addr;
        logic         e_wdf;
        logic [127:0] e_dat;
        logic [15:0]  e_msk;
        logic         e_busy;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic vd, input logic [63:0] d, input logic fl,
                                input logic ld, input logic [30:0] sa, input logic phy,
                                input logic e_af, input logic [30:0] e_addr, input logic e_wdf,
                                input logic [127:0] e_dat, input logic [15:0] e_msk,
                                input logic e_busy);
        vec_t v;
        v.vd = vd; v.d = d; v.fl = fl; v.ld = ld; v.sa = sa; v.phy = phy;
        v.e_af = e_af; v.e_addr = e_addr; v.e_wdf = e_wdf;
        v.e_dat = e_dat; v.e_msk = e_msk; v.e_busy = e_busy;
        vq.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [63:0] d);
        din_vd = 1'b1;
        din    = d;
        cyc();
        din_vd = 1'b0;
    endtask

    initial begin
        logic ok;

        // Part A: single burst at 0x100
        add(0, 0, 0, 1, 31'h100, 1, 0, 0, 0, 0, 0, 0);
        add(1, 64'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 64'h2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 64'h3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 64'h4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 31'h100, 1, {64'h2, 64'h1}, 16'h0000, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, {64'h4, 64'h3}, 16'h0000, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Part B: 16 words buffered while uncalibrated, then four gapless bursts
        for (int i = 0; i < 16; i++)
            add(1, 64'(16 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 4; j++) begin
            add(0, 0, 0, 0, 0, 1, 1, 31'(32'h104 + 4 * j), 1,
                {64'(17 + 4 * j), 64'(16 + 4 * j)}, 16'h0000, 1);
            add(0, 0, 0, 0, 0, 1, 0, 0, 1,
                {64'(19 + 4 * j), 64'(18 + 4 * j)}, 16'h0000, (j < 3));
        end
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Part C: three words then flush, then flush of an empty buffer
        add(1, 64'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 64'h22, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 64'h23, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 31'h114, 1, {64'h22, 64'h21}, 16'h0000, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, {64'h0, 64'h23}, 16'hFF00, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) cyc();
        chk("rst_af_wren", app_af_wren, 1'b0);
        chk("rst_wdf_wren", app_wdf_wren, 1'b0);
        chk("rst_addr", app_af_addr, 31'h0);
        chk("rst_busy_ovf", {busy, overflow}, 2'b00);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            din_vd        = vq[i].vd;
            din           = vq[i].d;
            flush         = vq[i].fl;
            load_addr     = vq[i].ld;
            start_addr    = vq[i].sa;
            phy_init_done = vq[i].phy;
            cyc();
            ok = (app_af_wren === vq[i].e_af) && (app_wdf_wren === vq[i].e_wdf) &&
                 (busy === vq[i].e_busy) && (overflow === 1'b0) && (app_af_cmd === 3'b000);
            if (vq[i].e_af && (app_af_addr !== vq[i].e_addr))
                ok = 1'b0;
            if (vq[i].e_wdf && ((app_wdf_data !== vq[i].e_dat) || (app_wdf_mask_data !== vq[i].e_msk)))
                ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: af=%b addr=%h wdf=%b dat=%h msk=%h busy=%b ovf=%b; expected af=%b addr=%h wdf=%b dat=%h msk=%h busy=%b ovf=0",
                         i, app_af_wren, app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data,
                         busy, overflow, vq[i].e_af, vq[i].e_addr, vq[i].e_wdf, vq[i].e_dat,
                         vq[i].e_msk, vq[i].e_busy);
            end
        end
        din_vd = 1'b0; flush = 1'b0; load_addr = 1'b0; phy_init_done = 1'b1;

        // D: app_wdf_afull stalls beat1 for exactly 5 cycles
        for (int i = 0; i < 4; i++) push(64'(32'h31 + i));
        cyc();
        chk("d_launch_addr", {app_af_wren, app_af_addr}, {1'b1, 31'h118});
        chk("d_beat0", app_wdf_data, {64'h32, 64'h31});
        app_wdf_afull = 1'b1;
        repeat (5) begin
            cyc();
            chk("d_hold", {app_af_wren, app_wdf_wren}, 2'b00);
        end
        app_wdf_afull = 1'b0;
        cyc();
        chk("d_beat1", {app_wdf_wren, app_wdf_data, app_wdf_mask_data}, {1'b1, 64'h34, 64'h33, 16'h0});
        cyc();
        chk("d_after", app_wdf_wren, 1'b0);

        // E: no launch until calibration completes
        phy_init_done = 1'b0;
        for (int i = 0; i < 4; i++) push(64'(32'h51 + i));
        repeat (3) begin
            cyc();
            chk("e_wait", {app_af_wren, app_wdf_wren}, 2'b00);
        end
        phy_init_done = 1'b1;
        cyc();
        chk("e_launch", {app_af_wren, app_af_addr, app_wdf_data}, {1'b1, 31'h11C, 64'h52, 64'h51});
        cyc();
        chk("e_beat1", {app_wdf_wren, app_wdf_data}, {1'b1, 64'h54, 64'h53});

        // F: overflow while the address FIFO is almost full
        app_af_afull = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(64'(32'h60 + i));
            if (i == 15) chk("f_ovf_clear", overflow, 1'b0);
            if (i == 16) chk("f_ovf_set", overflow, 1'b1);
        end
        repeat (3) begin
            cyc();
            chk("f_sticky", {overflow, app_af_wren, busy}, 3'b101);
        end
        app_af_afull = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("f_cmd", {app_af_wren, app_af_addr, app_wdf_data},
                {1'b1, 31'(32'h120 + 4 * j), 64'(32'h61 + 4 * j), 64'(32'h60 + 4 * j)});
            cyc();
            chk("f_beat1", {app_wdf_wren, app_wdf_data},
                {1'b1, 64'(32'h63 + 4 * j), 64'(32'h62 + 4 * j)});
        end
        cyc();
        chk("f_drained", {app_wdf_wren, busy, overflow}, 3'b001);

        // G: asynchronous reset inside a burst, then load_addr corner cases
        for (int i = 0; i < 4; i++) push(64'(32'h81 + i));
        cyc();
        chk("g_launch", {app_af_wren, app_af_addr}, {1'b1, 31'h130});
        #2 reset = 1'b0;
        #1;
        chk("g_rst_strobes", {app_af_wren, app_wdf_wren}, 2'b00);
        chk("g_rst_state", {app_af_addr, busy, overflow}, {31'h0, 2'b00});
        reset = 1'b1;
        cyc();
        push(64'h91);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("g_partial0", {app_af_wren, app_af_addr, app_wdf_data, app_wdf_mask_data},
            {1'b1, 31'h0, 64'h0, 64'h91, 16'hFF00});
        load_addr = 1'b1; start_addr = 31'h200;
        cyc();
        load_addr = 1'b0;
        chk("g_partial1", {app_wdf_wren, app_wdf_data, app_wdf_mask_data}, {1'b1, 128'h0, 16'hFFFF});
        for (int i = 0; i < 4; i++) push(64'(32'hA1 + i));
        load_addr = 1'b1; start_addr = 31'h300;
        cyc();
        load_addr = 1'b0;
        chk("g_ld_ignored", {app_af_wren, app_af_addr, app_wdf_data}, {1'b1, 31'h4, 64'hA2, 64'hA1});
        cyc();
        chk("g_beat1", {app_wdf_wren, app_wdf_data}, {1'b1, 64'hA4, 64'hA3});
        for (int i = 0; i < 4; i++) push(64'(32'hB1 + i));
        cyc();
        chk("g_ld_launch", {app_af_wren, app_af_addr, app_wdf_data}, {1'b1, 31'h300, 64'hB2, 64'hB1});
        cyc();
        chk("g_ld_beat1", {app_wdf_wren, app_wdf_data}, {1'b1, 64'hB4, 64'hB3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
